wb_stage: RTL and testbench



---
 rtl/rv_pkg.sv | 25 ++
 rtl/wb_stage_load_align.sv | 44 ++++
 rtl/wb_stage.sv | 161 ++++++++++++++++
 tb/tb_wb_stage.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared constants and types for the write-back stage.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // Load-type encodings carried in funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    WRITE     = 2'd2
  } wb_state_t;

  // A write only reaches the register file when requested and not aimed at x0
  function automatic logic wr_enabled(input logic wen, input logic [REG_ADDR_W-1:0] rd);
    return wen && (rd != '0);
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment: picks the addressed byte/half/word out of the raw
// memory word, extends it to XLEN and flags misaligned halfword/word loads.
// Undefined funct3 encodings fall through to word behaviour.
module load_align
  import rv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [2:0]   funct3,
  input  logic [1:0]   addr,
  input  logic [W-1:0] rdata,
  output logic [W-1:0] data,
  output logic         misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr, 3'b000} +: 8];
  assign half_sel = rdata[{addr[1], 4'b0000} +: 16];

  // Extract and extend according to the load type
  always_comb begin
    data       = rdata;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = {{(W-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(W-8){1'b0}}, byte_sel};
      F3_LH: begin
        data       = {{(W-16){half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      F3_LHU: begin
        data       = {{(W-16){1'b0}}, half_sel};
        misaligned = addr[0];
      end
      default: begin
        data       = rdata;
        misaligned = (addr != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: accepts retiring instructions from MEM, waits for load
// responses, and issues one single-cycle register-file write per instruction.
// Optional: define WB_RETIRE_CNT_EN to add the retireCount output.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | nothing in flight, ready to accept
// WAIT_LOAD | load accepted, waiting for dmemRspValid, not ready
// WRITE     | write/misalign pulse presented this cycle, ready to accept
module wb_stage
  import rv_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [REG_ADDR_W-1:0] rdAddr,
  input  logic                  regWriteIn,
  input  logic                  memToReg,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       aluResult,
  input  logic                  dmemRspValid,
  input  logic [XLEN-1:0]       dmemRdata,
  output logic [REG_ADDR_W-1:0] writeReg,
  output logic [XLEN-1:0]       writeData,
  output logic                  regWrite,
  output logic                  misalignErr
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]           retireCount
`endif
);

  wb_state_t             state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  wen_q, wen_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            addr_q, addr_d;
  logic [REG_ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;
  logic                  reg_write_q, reg_write_d;
  logic                  misalign_q, misalign_d;

  logic                  accept;
  logic [XLEN-1:0]       ld_data;
  logic                  ld_mis;

  // Load extraction works on the captured funct3/address and live memory data
  load_align #(.W(XLEN)) u_load_align (
    .funct3     (f3_q),
    .addr       (addr_q),
    .rdata      (dmemRdata),
    .data       (ld_data),
    .misaligned (ld_mis)
  );

  assign accept = inValid && in_ready_q;

  // Next-state and next-output decode; outputs are all registered
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    wen_d       = wen_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    reg_write_d = 1'b0;
    misalign_d  = 1'b0;

    case (state_q)
      WAIT_LOAD: begin
        if (dmemRspValid) begin
          state_d = WRITE;
          if (ld_mis) begin
            // Misaligned: the error pulse replaces the write, data regs hold
            misalign_d = 1'b1;
          end else begin
            wr_reg_d    = rd_q;
            wr_data_d   = ld_data;
            reg_write_d = wr_enabled(wen_q, rd_q);
          end
        end
      end
      default: begin
        if (accept) begin
          rd_d   = rdAddr;
          wen_d  = regWriteIn;
          f3_d   = funct3;
          addr_d = aluResult[1:0];
          if (memToReg) begin
            state_d = WAIT_LOAD;
          end else begin
            // ALU results need no wait: write lands the next cycle
            state_d     = WRITE;
            wr_reg_d    = rdAddr;
            wr_data_d   = aluResult;
            reg_write_d = wr_enabled(regWriteIn, rdAddr);
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    in_ready_d = (state_d != WAIT_LOAD);
  end

  // State and output registers; reset discards any pending load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      rd_q        <= '0;
      wen_q       <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      reg_write_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      rd_q        <= rd_d;
      wen_q       <= wen_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      reg_write_q <= reg_write_d;
      misalign_q  <= misalign_d;
    end
  end

  assign inReady     = in_ready_q;
  assign writeReg    = wr_reg_q;
  assign writeData   = wr_data_q;
  assign regWrite    = reg_write_q;
  assign misalignErr = misalign_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  // Every instruction spends exactly one cycle in WRITE, so that cycle retires it
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (state_q == WRITE) retire_cnt_d = retire_cnt_q + 32'd1;
  end

  // Retire counter register, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retire_cnt_q <= '0;
    else       retire_cnt_q <= retire_cnt_d;
  end

  assign retireCount = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [4:0]  rdAddr;
  logic        regWriteIn;
  logic        memToReg;
  logic [2:0]  funct3;
  logic [31:0] aluResult;
  logic        dmemRspValid;
  logic [31:0] dmemRdata;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        regWrite;
  logic        misalignErr;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retireCount;
`endif

  int vectors = 0;
  int errors  = 0;

  wb_stage dut (
    .clk          (clk),
    .reset        (reset),
    .inValid      (inValid),
    .inReady      (inReady),
    .rdAddr       (rdAddr),
    .regWriteIn   (regWriteIn),
    .memToReg     (memToReg),
    .funct3       (funct3),
    .aluResult    (aluResult),
    .dmemRspValid (dmemRspValid),
    .dmemRdata    (dmemRdata),
    .writeReg     (writeReg),
    .writeData    (writeData),
    .regWrite     (regWrite),
    .misalignErr  (misalignErr)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retireCount  (retireCount)
`endif
  );

  always #5 clk = ~clk;

  // Reference load semantics computed arithmetically from the load rules
  function automatic void ref_load(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] w, output logic [31:0] d,
                                   output logic mis);
    int unsigned b, h, lo;
    lo = a % 4;
    b  = (w >> (8 * lo)) & 32'hFF;
    h  = (w >> (16 * (lo / 2))) & 32'hFFFF;
    case (f3)
      3'd0: begin d = (b >= 128) ? b + 32'hFFFF_FF00 : b; mis = 1'b0; end
      3'd4: begin d = b; mis = 1'b0; end
      3'd1: begin d = (h >= 32768) ? h + 32'hFFFF_0000 : h; mis = (lo % 2) != 0; end
      3'd5: begin d = h; mis = (lo % 2) != 0; end
      default: begin d = w; mis = (lo != 0); end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for one accepting edge
  task automatic issue(input logic [4:0] rd, input logic wen, input logic mem,
                       input logic [2:0] f3, input logic [31:0] a);
    rdAddr = rd; regWriteIn = wen; memToReg = mem; funct3 = f3; aluResult = a;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] w);
    dmemRdata = w;
    dmemRspValid = 1'b1;
    tick();
    dmemRspValid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (inReady !== 1'b1 || regWrite !== 1'b0 || misalignErr !== 1'b0 ||
        writeReg !== 5'd0 || writeData !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b we=%b mis=%b reg=%0d data=%h, want rdy=1 we=0 mis=0 reg=0 data=0",
               inReady, regWrite, misalignErr, writeReg, writeData);
    end
`ifdef WB_RETIRE_CNT_EN
    vectors++;
    if (retireCount !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d want 0", retireCount);
    end
`endif
  endtask

  task automatic test_alu();
    issue(5'd5, 1'b1, 1'b0, 3'd0, 32'h1234_5678);
    vectors++;
    if (regWrite !== 1'b1 || writeReg !== 5'd5 || writeData !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alu_write: got we=%b reg=%0d data=%h, want we=1 reg=5 data=12345678",
               regWrite, writeReg, writeData);
    end
    tick();
    vectors++;
    if (regWrite !== 1'b0 || writeData !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alu_after: got we=%b data=%h, want we=0 data=12345678 (held)", regWrite, writeData);
    end
  endtask

  task automatic test_lb();
    issue(5'd7, 1'b1, 1'b1, 3'b000, 32'h0000_1001);
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (inReady !== 1'b0 || regWrite !== 1'b0) begin
        errors++;
        $display("FAIL lb_wait: cycle %0d got rdy=%b we=%b, want rdy=0 we=0", c, inReady, regWrite);
      end
      tick();
    end
    respond(32'h0000_8000);
    vectors++;
    if (regWrite !== 1'b1 || writeReg !== 5'd7 || writeData !== 32'hFFFF_FF80 || inReady !== 1'b1) begin
      errors++;
      $display("FAIL lb_sext: got we=%b reg=%0d data=%h rdy=%b, want we=1 reg=7 data=ffffff80 rdy=1",
               regWrite, writeReg, writeData, inReady);
    end
    tick();
  endtask

  task automatic test_lhu();
    issue(5'd9, 1'b1, 1'b1, 3'b101, 32'h0000_2002);
    respond(32'hBEEF_0000);
    vectors++;
    if (regWrite !== 1'b1 || writeData !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL lhu_zext: got we=%b data=%h, want we=1 data=0000beef", regWrite, writeData);
    end
    tick();
  endtask

  task automatic test_x0_misalign();
    issue(5'd0, 1'b1, 1'b0, 3'd0, 32'hCAFE_0001);
    vectors++;
    if (regWrite !== 1'b0 || writeData !== 32'hCAFE_0001 || writeReg !== 5'd0) begin
      errors++;
      $display("FAIL x0_suppress: got we=%b reg=%0d data=%h, want we=0 reg=0 data=cafe0001",
               regWrite, writeReg, writeData);
    end
    tick();
    issue(5'd4, 1'b1, 1'b1, 3'b010, 32'h0000_0102);
    respond(32'h1111_2222);
    vectors++;
    if (misalignErr !== 1'b1 || regWrite !== 1'b0) begin
      errors++;
      $display("FAIL lw_misalign: got mis=%b we=%b, want mis=1 we=0", misalignErr, regWrite);
    end
    tick();
    vectors++;
    if (misalignErr !== 1'b0 || regWrite !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse: got mis=%b we=%b, want mis=0 we=0", misalignErr, regWrite);
    end
    // A stray response while idle must do nothing
    respond(32'h5555_AAAA);
    vectors++;
    if (regWrite !== 1'b0 || misalignErr !== 1'b0 || inReady !== 1'b1) begin
      errors++;
      $display("FAIL stray_rsp: got we=%b mis=%b rdy=%b, want we=0 mis=0 rdy=1", regWrite, misalignErr, inReady);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      rdAddr = 5'(i); regWriteIn = 1'b1; memToReg = 1'b0; funct3 = 3'd0;
      aluResult = 32'h100 + 32'(i);
      inValid = 1'b1;
      tick();
      vectors++;
      if (regWrite !== 1'b1 || writeReg !== 5'(i) || writeData !== 32'h100 + 32'(i)) begin
        errors++;
        $display("FAIL b2b_write: op %0d got we=%b reg=%0d data=%h, want we=1 reg=%0d data=%h",
                 i, regWrite, writeReg, writeData, i, 32'h100 + 32'(i));
      end
    end
    inValid = 1'b0;
    tick();
    vectors++;
    if (regWrite !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got we=%b want 0", regWrite);
    end
  endtask

  task automatic test_reset_wait();
    issue(5'd12, 1'b1, 1'b1, 3'b010, 32'h0000_0400);
    tick();
    reset = 1'b1;
    #2;
    vectors++;
    if (inReady !== 1'b1 || regWrite !== 1'b0 || writeReg !== 5'd0 || writeData !== 32'd0) begin
      errors++;
      $display("FAIL reset_async: got rdy=%b we=%b reg=%0d data=%h, want rdy=1 we=0 reg=0 data=0",
               inReady, regWrite, writeReg, writeData);
    end
    tick();
    reset = 1'b0;
    respond(32'h7777_8888);
    for (int c = 0; c < 2; c++) begin
      vectors++;
      if (regWrite !== 1'b0 || writeData !== 32'd0 || inReady !== 1'b1) begin
        errors++;
        $display("FAIL late_rsp: cycle %0d got we=%b data=%h rdy=%b, want we=0 data=0 rdy=1",
                 c, regWrite, writeData, inReady);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3s [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    logic [4:0]  rd;
    logic        wen, mem, exp_mis, exp_we;
    logic [2:0]  f3;
    logic [31:0] a, w, exp_d;
    int          nd;
    int unsigned exp_cnt;
    do_reset();
    exp_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      rd  = 5'($urandom_range(0, 31));
      wen = ($urandom_range(0, 3) != 0);
      mem = 1'($urandom_range(0, 1));
      f3  = f3s[$urandom_range(0, 7)];
      a   = $urandom;
      w   = $urandom;
      vectors++;
      if (inReady !== 1'b1) begin
        errors++;
        $display("FAIL rnd_ready: op %0d got %b want 1", k, inReady);
      end
      issue(rd, wen, mem, f3, a);
      if (mem) begin
        nd = $urandom_range(0, 3);
        for (int c = 0; c <= nd; c++) begin
          vectors++;
          if (inReady !== 1'b0 || regWrite !== 1'b0 || misalignErr !== 1'b0) begin
            errors++;
            $display("FAIL rnd_wait: op %0d got rdy=%b we=%b mis=%b, want 0 0 0", k, inReady, regWrite, misalignErr);
          end
          if (c < nd) tick();
        end
        respond(w);
        ref_load(f3, a, w, exp_d, exp_mis);
      end else begin
        exp_d = a;
        exp_mis = 1'b0;
      end
      exp_we = !exp_mis && wen && (rd != 5'd0);
      vectors++;
      if (regWrite !== exp_we || misalignErr !== exp_mis ||
          (!exp_mis && (writeReg !== rd || writeData !== exp_d))) begin
        errors++;
        $display("FAIL rnd_result: op %0d f3=%0d mem=%b got we=%b mis=%b reg=%0d data=%h, want we=%b mis=%b reg=%0d data=%h",
                 k, f3, mem, regWrite, misalignErr, writeReg, writeData, exp_we, exp_mis, rd, exp_d);
      end
      exp_cnt++;
      if ($urandom_range(0, 2) == 0) begin
        tick();
        vectors++;
        if (regWrite !== 1'b0 || misalignErr !== 1'b0) begin
          errors++;
          $display("FAIL rnd_idle: op %0d got we=%b mis=%b, want 0 0", k, regWrite, misalignErr);
        end
      end
    end
    tick();
    tick();
`ifdef WB_RETIRE_CNT_EN
    vectors++;
    if (retireCount !== exp_cnt) begin
      errors++;
      $display("FAIL rnd_retire: got %0d want %0d", retireCount, exp_cnt);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; inValid = 1'b0; rdAddr = '0; regWriteIn = 1'b0; memToReg = 1'b0;
    funct3 = '0; aluResult = '0; dmemRspValid = 1'b0; dmemRdata = '0;
    #1;
    test_reset();
    test_alu();
    test_lb();
    test_lhu();
    test_x0_misalign();
    test_back_to_back();
    test_reset_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
